// File: rtl/video_timing_source.sv
// Frame-stream transmitter: pulls pixels from a valid/ready source and wraps
// them in vsync/href/clken frame timing for the downstream video pipeline.
module video_timing_source #(
    parameter int DATA_WIDTH = 24,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int H_BLANK    = 160,
    parameter int VS_LEAD    = 16,
    parameter int V_BLANK    = 800
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  post_frame_vsync,
    output logic                  post_frame_href,
    output logic                  post_frame_clken,
    output logic [DATA_WIDTH-1:0] post_img,
    output logic                  frame_done,
    output logic                  busy
);

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // One shared cycle counter serves VS_LEAD, HBLANK and VBLANK.
    localparam int CNT_MAX = max3(VS_LEAD, H_BLANK, V_BLANK);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PIX_W   = $clog2(H_ACTIVE + 1);
    localparam int LINE_W  = $clog2(V_ACTIVE + 1);

    localparam logic [CNT_W-1:0]  LEAD_LAST = CNT_W'(VS_LEAD - 1);
    localparam logic [CNT_W-1:0]  HB_LAST   = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0]  VB_LAST   = CNT_W'(V_BLANK - 1);
    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(H_ACTIVE - 1);
    localparam logic [LINE_W-1:0] LINE_END  = LINE_W'(V_ACTIVE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VS_LEAD,
        S_LINE,
        S_HBLANK,
        S_VBLANK
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PIX_W-1:0]        pix_q, pix_d;
    logic [LINE_W-1:0]       line_q, line_d;
    logic                    accept;

    logic                    vsync_q, vsync_d;
    logic                    href_q, href_d;
    logic                    clken_q, clken_d;
    logic [DATA_WIDTH-1:0]   img_q, img_d;
    logic                    done_q, done_d;

    // Next-state and counter update; enable is only looked at in IDLE and on the last VBLANK cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pix_d   = pix_q;
        line_d  = line_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_VS_LEAD;
                    cnt_d   = '0;
                end
            end
            S_VS_LEAD: begin
                if (cnt_q == LEAD_LAST) begin
                    state_d = S_LINE;
                    cnt_d   = '0;
                    pix_d   = '0;
                    line_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LINE: begin
                if (s_valid) begin
                    accept = 1'b1;
                    if (pix_q == PIX_LAST) begin
                        state_d = S_HBLANK;
                        cnt_d   = '0;
                        pix_d   = '0;
                    end else begin
                        pix_d = pix_q + PIX_W'(1);
                    end
                end
            end
            S_HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    line_d = line_q + LINE_W'(1);
                    cnt_d  = '0;
                    if (line_d == LINE_END) begin
                        state_d = S_VBLANK;
                    end else begin
                        state_d = S_LINE;
                        pix_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_VBLANK: begin
                if (cnt_q == VB_LAST) begin
                    cnt_d   = '0;
                    state_d = enable ? S_VS_LEAD : S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                pix_d   = '0;
                line_d  = '0;
            end
        endcase
    end

    // Bus values derived from the current state, so every post_* bit lags state by one edge together.
    always_comb begin
        vsync_d = (state_q == S_VS_LEAD) || (state_q == S_LINE) || (state_q == S_HBLANK);
        href_d  = (state_q == S_LINE);
        clken_d = accept;
        img_d   = accept ? s_data : img_q;
        done_d  = (state_q == S_VBLANK) && (cnt_q == VB_LAST);
    end

    // State, counters and registered bus outputs; reset abandons any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pix_q   <= '0;
            line_q  <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            clken_q <= 1'b0;
            img_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            clken_q <= clken_d;
            img_q   <= img_d;
            done_q  <= done_d;
        end
    end

    // Ready comes from registered state only, never from s_valid.
    assign s_ready          = (state_q == S_LINE);
    assign busy             = (state_q != S_IDLE);
    assign post_frame_vsync = vsync_q;
    assign post_frame_href  = href_q;
    assign post_frame_clken = clken_q;
    assign post_img         = img_q;
    assign frame_done       = done_q;

endmodule

// File: tb/tb_video_timing_source.sv
// Bench for video_timing_source with a small frame geometry.
`timescale 1ns/1ps
module tb_video_timing_source;

    localparam int DW = 8;
    localparam int HA = 4;
    localparam int VA = 3;
    localparam int HB = 2;
    localparam int VL = 3;
    localparam int VB = 5;
    localparam int SCN_CYC = 100;
    localparam int N  = 400;
    localparam int NA = N + 200;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          vs;
    logic          href;
    logic          clken;
    logic [DW-1:0] img;
    logic          frame_done;
    logic          busy;

    int checks = 0;
    int errors = 0;

    video_timing_source #(
        .DATA_WIDTH(DW), .H_ACTIVE(HA), .V_ACTIVE(VA),
        .H_BLANK(HB), .VS_LEAD(VL), .V_BLANK(VB)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .post_frame_vsync (vs),
        .post_frame_href  (href),
        .post_frame_clken (clken),
        .post_img         (img),
        .frame_done       (frame_done),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Bus nesting must hold on every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ((clken && !href) || (href && !vs)) begin
                errors++;
                $display("FAIL bus_nesting vsync=%0d href=%0d clken=%0d expected nested", vs, href, clken);
            end
        end
    end

    task automatic do_reset();
        rst_n   = 1'b0;
        enable  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int all_out();
        return int'({vs, href, clken, img, frame_done, busy, s_ready});
    endfunction

    typedef struct {
        int en_cycles;
        int stall_at;
        int stall_len;
        int frames;
        int pix;
        int vs0;
        int href0;
    } scn_t;

    scn_t scn [4];

    task automatic run_scn(input int id, input scn_t s);
        int frames = 0, pix = 0, fds = 0, vs0 = 0, h0 = 0, ord_err = 0, dcnt = 0;
        bit prev_vs = 0, prev_hr = 0, vs0_done = 0, h0_done = 0;
        logic [DW-1:0] exp_px = '0;
        do_reset();
        for (int c = 0; c < SCN_CYC; c++) begin
            if (vs && !prev_vs) frames++;
            if (vs && frames == 1 && !vs0_done) vs0++;
            if (!vs && prev_vs) vs0_done = 1;
            if (href && !h0_done) h0++;
            if (!href && prev_hr) h0_done = 1;
            if (clken) begin
                if (img != exp_px) ord_err++;
                exp_px++;
                pix++;
            end
            if (frame_done) fds++;
            prev_vs = vs;
            prev_hr = href;
            enable  = (c < s.en_cycles);
            s_valid = !(c >= s.stall_at && c < s.stall_at + s.stall_len);
            s_data  = DW'(dcnt);
            if (s_valid && s_ready) dcnt++;
            @(negedge clk);
        end
        chk($sformatf("scn%0d_frames", id), frames, s.frames);
        chk($sformatf("scn%0d_pixels", id), pix, s.pix);
        chk($sformatf("scn%0d_frame_done", id), fds, s.frames);
        chk($sformatf("scn%0d_vsync_len", id), vs0, s.vs0);
        chk($sformatf("scn%0d_href0_len", id), h0, s.href0);
        chk($sformatf("scn%0d_data_order_errs", id), ord_err, 0);
        chk($sformatf("scn%0d_busy_end", id), int'(busy), 0);
    endtask

    // Expected per-cycle frame phase: 0 idle, 1 lead, 2 line, 3 hblank, 4 vblank.
    bit            en_a [NA];
    bit            vl_a [NA];
    logic [DW-1:0] dat  [NA];
    int            ph   [NA];
    bit            fd_a [NA];
    int            m_c;

    task automatic put(input int p, input bit f);
        if (m_c < NA) begin
            ph[m_c]   = p;
            fd_a[m_c] = f;
        end
        m_c++;
    endtask

    task automatic build_phases();
        bit again;
        m_c = 0;
        while (m_c < N) begin
            if (!en_a[m_c]) begin
                put(0, 0);
                continue;
            end
            put(0, 0);
            do begin
                for (int i = 0; i < VL; i++) put(1, 0);
                for (int l = 0; l < VA; l++) begin
                    int npix = 0;
                    while (npix < HA && m_c < NA) begin
                        if (vl_a[m_c]) npix++;
                        put(2, 0);
                    end
                    for (int i = 0; i < HB; i++) put(3, 0);
                end
                for (int i = 0; i < VB; i++) put(4, i == VB - 1);
                again = (m_c - 1 < NA) && en_a[m_c - 1];
            end while (again && m_c < N);
        end
    endtask

    initial begin
        int dcnt;
        logic [DW-1:0] last_img;
        int k;

        scn[0] = '{5,  0, 0, 1, 12, 21, 4};
        scn[1] = '{5,  6, 3, 1, 12, 24, 7};
        scn[2] = '{60, 0, 0, 3, 36, 21, 4};
        scn[3] = '{11, 0, 0, 1, 12, 21, 4};

        // Reset and idle with enable low.
        rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = '0;
        #2;
        chk("reset_outputs", all_out(), 0);
        do_reset();
        for (int i = 0; i < 50; i++) begin
            s_valid = 1'(i % 2);
            s_data  = DW'(i);
            @(negedge clk);
            chk("idle_outputs", all_out(), 0);
        end

        for (int i = 0; i < 4; i++) run_scn(i, scn[i]);

        // Asynchronous reset during line 1, then restart with enable held.
        do_reset();
        enable  = 1'b1;
        s_valid = 1'b1;
        dcnt    = 0;
        for (int c = 0; c < 11; c++) begin
            s_data = DW'(dcnt);
            if (s_ready) dcnt++;
            @(negedge clk);
        end
        chk("line1_ready", int'(s_ready), 1);
        chk("line1_href", int'(href), 1);
        s_data = DW'(dcnt);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", all_out(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_busy", int'(busy), 1);
        chk("restart_vsync_c1", int'(vs), 0);
        @(negedge clk);
        chk("restart_vsync_c2", int'(vs), 1);
        chk("restart_href_c2", int'(href), 0);
        @(negedge clk);
        @(negedge clk);
        chk("restart_ready_c4", int'(s_ready), 1);
        chk("restart_href_c4", int'(href), 0);
        @(negedge clk);
        chk("restart_href_c5", int'(href), 1);
        chk("restart_clken_c5", int'(clken), 1);
        chk("restart_first_pix", int'(img), 5);

        // Randomized enable/valid/data against the expected frame layout.
        for (int i = 0; i < NA; i++) begin
            en_a[i] = (i < 300) ? ($urandom_range(0, 7) != 0) : 1'b0;
            vl_a[i] = ($urandom_range(0, 3) != 0);
            dat[i]  = DW'($urandom_range(0, 255));
            ph[i]   = 0;
            fd_a[i] = 0;
        end
        build_phases();
        do_reset();
        last_img = '0;
        k = 0;
        for (int c = 0; c < N; c++) begin
            int pc;
            pc = (c == 0) ? 0 : ph[c - 1];
            chk("rnd_vsync", int'(vs), int'(pc == 1 || pc == 2 || pc == 3));
            chk("rnd_href", int'(href), int'(pc == 2));
            chk("rnd_clken", int'(clken), int'(c > 0 && pc == 2 && vl_a[c - 1]));
            chk("rnd_img", int'(img), int'(last_img));
            chk("rnd_frame_done", int'(frame_done), int'(c > 0 && fd_a[c - 1]));
            chk("rnd_busy", int'(busy), int'(ph[c] != 0));
            chk("rnd_ready", int'(s_ready), int'(ph[c] == 2));
            enable  = en_a[c];
            s_valid = vl_a[c];
            if (ph[c] == 2) begin
                s_data = dat[k];
                if (vl_a[c]) begin
                    last_img = dat[k];
                    k++;
                end
            end else begin
                s_data = DW'($urandom_range(0, 255));
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
